id_ex_stage: RTL

Decode-to-execute pipeline stage of the five-stage CPU. It sits directly downstream of the register file. It captures RD1/RD2, register specifiers, immediate and control into execute-stage registers, and bypasses a same-cycle write-back around the register file write delay. It drives forwarded operands to the ALU, detects load-use hazards, stalls fetch/decode, and inserts bubbles on stall or branch/jump flush.

---
 rtl/id_ex_stage_if.sv | 55 +++++
 rtl/id_ex_stage.sv | 104 ++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// Decode/execute stage bus: decode fields and M/W producers in, execute registers and forwarded operands out.
// The stage itself takes the slave modport; the surrounding pipeline (or bench) drives through master.
interface id_ex_stage_if;
   logic               ValidD;
   logic signed [31:0] RD1D;
   logic signed [31:0] RD2D;
   logic [4:0]         RsD;
   logic [4:0]         RtD;
   logic [4:0]         RdD;
   logic [31:0]        ImmD;
   logic [31:0]        PCPlus1D;
   logic               RegWriteD;
   logic               MemtoRegD;
   logic               MemWriteD;
   logic [7:0]         CtrlD;
   logic [4:0]         WriteRegM;
   logic               RegWriteM;
   logic [31:0]        ALUOutM;
   logic [4:0]         WriteRegW;
   logic               RegWriteW;
   logic [31:0]        ResultW;
   logic               FlushE;

   logic               StallD;
   logic signed [31:0] SrcAE;
   logic signed [31:0] SrcBE;
   logic [4:0]         RsE;
   logic [4:0]         RtE;
   logic [4:0]         RdE;
   logic [31:0]        ImmE;
   logic [31:0]        PCPlus1E;
   logic [7:0]         CtrlE;
   logic               RegWriteE;
   logic               MemtoRegE;
   logic               MemWriteE;
   logic               ValidE;
   logic [15:0]        StallCount;
   logic [15:0]        FlushCount;

   modport slave (
      input  ValidD, RD1D, RD2D, RsD, RtD, RdD, ImmD, PCPlus1D,
             RegWriteD, MemtoRegD, MemWriteD, CtrlD,
             WriteRegM, RegWriteM, ALUOutM, WriteRegW, RegWriteW, ResultW, FlushE,
      output StallD, SrcAE, SrcBE, RsE, RtE, RdE, ImmE, PCPlus1E, CtrlE,
             RegWriteE, MemtoRegE, MemWriteE, ValidE, StallCount, FlushCount
   );

   modport master (
      output ValidD, RD1D, RD2D, RsD, RtD, RdD, ImmD, PCPlus1D,
             RegWriteD, MemtoRegD, MemWriteD, CtrlD,
             WriteRegM, RegWriteM, ALUOutM, WriteRegW, RegWriteW, ResultW, FlushE,
      input  StallD, SrcAE, SrcBE, RsE, RtE, RdE, ImmE, PCPlus1E, CtrlE,
             RegWriteE, MemtoRegE, MemWriteE, ValidE, StallCount, FlushCount
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with W-bypass at capture, M/W operand forwarding, load-use stall and flush bubbles.
// Latency 1 cycle decode->E; no handshake, StallD holds upstream for exactly one cycle per load-use.
module id_ex_stage (
   input  logic         CLK,
   input  logic         RESET,
   id_ex_stage_if.slave bus
);
   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        memto_reg;
      logic        mem_write;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc_plus1;
      logic [7:0]  ctrl;
   } ex_t;

   ex_t         ex_q, ex_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;
   logic        lwstall;

   always_comb begin
      lwstall = ex_q.valid & ex_q.memto_reg & ex_q.reg_write & (ex_q.rt != 5'd0) &
                bus.ValidD & ((ex_q.rt == bus.RsD) | (ex_q.rt == bus.RtD));
   end

   // Flush wins over stall: the decode slot is wrong-path, so fetch must not be held.
   always_comb begin
      ex_d = '0;
      if (!bus.FlushE && !lwstall) begin
         ex_d.valid     = bus.ValidD;
         ex_d.reg_write = bus.RegWriteD;
         ex_d.memto_reg = bus.MemtoRegD;
         ex_d.mem_write = bus.MemWriteD;
         ex_d.rs        = bus.RsD;
         ex_d.rt        = bus.RtD;
         ex_d.rd        = bus.RdD;
         ex_d.imm       = bus.ImmD;
         ex_d.pc_plus1  = bus.PCPlus1D;
         ex_d.ctrl      = bus.CtrlD;
         // Register file write lands after its read, so take the W result directly.
         ex_d.rd1 = (bus.RegWriteW && (bus.WriteRegW == bus.RsD) && (bus.RsD != 5'd0))
                    ? bus.ResultW : bus.RD1D;
         ex_d.rd2 = (bus.RegWriteW && (bus.WriteRegW == bus.RtD) && (bus.RtD != 5'd0))
                    ? bus.ResultW : bus.RD2D;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (lwstall && !bus.FlushE && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
      if (bus.FlushE && (flush_cnt_q != 16'hFFFF))            flush_cnt_d = flush_cnt_q + 16'd1;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ex_q        <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // M is the younger producer, so it takes priority over W.
   always_comb begin
      if (bus.RegWriteM && (bus.WriteRegM == ex_q.rs) && (ex_q.rs != 5'd0))
         bus.SrcAE = bus.ALUOutM;
      else if (bus.RegWriteW && (bus.WriteRegW == ex_q.rs) && (ex_q.rs != 5'd0))
         bus.SrcAE = bus.ResultW;
      else
         bus.SrcAE = ex_q.rd1;

      if (bus.RegWriteM && (bus.WriteRegM == ex_q.rt) && (ex_q.rt != 5'd0))
         bus.SrcBE = bus.ALUOutM;
      else if (bus.RegWriteW && (bus.WriteRegW == ex_q.rt) && (ex_q.rt != 5'd0))
         bus.SrcBE = bus.ResultW;
      else
         bus.SrcBE = ex_q.rd2;
   end

   assign bus.StallD     = lwstall & ~bus.FlushE;
   assign bus.RsE        = ex_q.rs;
   assign bus.RtE        = ex_q.rt;
   assign bus.RdE        = ex_q.rd;
   assign bus.ImmE       = ex_q.imm;
   assign bus.PCPlus1E   = ex_q.pc_plus1;
   assign bus.CtrlE      = ex_q.ctrl;
   assign bus.RegWriteE  = ex_q.reg_write;
   assign bus.MemtoRegE  = ex_q.memto_reg;
   assign bus.MemWriteE  = ex_q.mem_write;
   assign bus.ValidE     = ex_q.valid;
   assign bus.StallCount = stall_cnt_q;
   assign bus.FlushCount = flush_cnt_q;
endmodule
